mv_result_collector: RTL and testbench
======================================

# mv_result_collector

Downstream stage of the matrix-by-vector engine. Captures each `NI*element_width` result chunk that the engine's decoder presents on its read-now strobe and stores it in an indexed buffer. Counts the captured chunks against a programmed total and flags completion. Provides a registered random-access read port, so the next CG step (dot product / vector update) can fetch the full result vector.

## Interface
Parameters:
- `element_width`, 32, bits per element
- `NI`, 8, elements per chunk (matches engine output width)
- `DEPTH`, 16, buffer capacity in chunks
- `ADDR_W`, 4, address width; `2**ADDR_W >= DEPTH`

Ports:
- `clk`  in  1  rising-edge clock, single clock domain
- `reset`  in  1  synchronous, active-low; sampled only on `clk` rise
- `start`  in  1  level; high = run, low = abort/clear (same semantics as engine `start`)
- `total_chunks`  in  32  expected chunk count; sampled on IDLE→COLLECT
- `in_valid`  in  1  engine read-now strobe, one cycle per chunk
- `in_data`  in  NI*element_width  engine output chunk; element 0 in MSBs
- `rd_en`  in  1  read request
- `rd_addr`  in  ADDR_W  chunk index to read
- `rd_data`  out  NI*element_width  registered read data
- `rd_valid`  out  1  high one cycle after an accepted `rd_en`
- `count`  out  ADDR_W+1  chunks captured this run
- `done`  out  1  all expected chunks captured
- `overflow`  out  1  sticky; a write was dropped because the buffer was full

## Operation
- Reset (`reset`==0 at edge): state IDLE. Outputs `count`=0, `done`=0, `overflow`=0, `rd_valid`=0, `rd_data`=0. Buffer contents are not cleared.
- States:
  - IDLE:
    - `start`=1 → latch `total_chunks` into `target`.
    - `target`==0 → DONE directly; otherwise → COLLECT.
    - `in_valid` is ignored.
  - COLLECT:
    - On `in_valid`=1 with `count`<DEPTH: `buf[count]`←`in_data`; `count`←`count`+1.
    - On `in_valid`=1 with `count`==DEPTH: data dropped; `overflow`←1.
    - When the write makes `count`==`target` → DONE, and `done`=1 from that same edge.
  - DONE:
    - `in_valid` is ignored and does not set `overflow`.
    - Holds until `start`=0.
- `start`=0 in any state → IDLE next edge, with `count`←0, `done`←0, `overflow`←0. Buffer is retained. An `in_valid` in the same cycle is dropped.
- `target`>DEPTH: collection stops at DEPTH, `overflow` sets on the next strobe, and `done` never asserts (run must be aborted).
- Read port:
  - Independent of state.
  - `rd_en`=1 → `rd_data`←`buf[rd_addr]` and `rd_valid`←1 at the next edge; otherwise `rd_valid`←0 and `rd_data` holds.
  - Read and write to the same address in one cycle returns the old contents (read-before-write).
  - `rd_addr`>=DEPTH returns 0.
- `reset` low while COLLECT aborts the run exactly as `start`=0 does, and additionally clears `rd_data`/`rd_valid`.
- `count` saturates at DEPTH; it never wraps.

## Timing
- Capture latency: `in_data` is written at the edge where `in_valid` is sampled high. `count` updates at that same edge.
- `done`: registered; high in the cycle after the final chunk's strobe edge.
- Read latency: 1 cycle (`rd_en` at edge N → `rd_data`/`rd_valid` valid after edge N, usable at edge N+1).
- Back-to-back `in_valid` on consecutive cycles is accepted at one chunk per cycle, with no stall and no backpressure.
- IDLE→COLLECT takes one edge. A strobe coinciding with the `start` rising edge is ignored, since the engine needs ≥6 cycles before its first output.

## Configuration
- `MV_COLLECTOR_ZERO_PAD_EN` defined: a read of any `rd_addr` >= `count` returns all-zero `rd_data`, so padding rows are masked. This covers unwritten or stale entries, including those from a previous run.
- Not defined: such reads return the raw buffer contents, including stale data. Applies in all states.

## Test plan
- Basic run: reset, `start`=1, `total_chunks`=4, four `in_valid` pulses with data 0x1…, 0x2…, 0x3…, 0x4… (replicated per element) → `count`=4 and `done`=1 the cycle after the 4th strobe; `rd_addr`=2 returns the 0x3… chunk one cycle after `rd_en`.
- Zero total: `total_chunks`=0, `start`=1 → `done`=1 two edges after `start`; `count`=0; strobes ignored.
- Overflow: DEPTH=16, `total_chunks`=20, 18 strobes → `count`=16, `overflow`=1 after the 17th strobe, `done`=0; `start`=0 → all clear next edge.
- Abort mid-run: 3 of 8 chunks captured, then `start`=0 for one cycle coincident with a strobe → `count`=0, `done`=0. Chunk 0 is still readable and equals the first data when `MV_COLLECTOR_ZERO_PAD_EN` is undefined; it reads 0 when defined.
- Read/write collision: `rd_en` with `rd_addr`=`count` in the same cycle as a strobe → the returned data is the prior contents (0 after reset-fresh run with ZERO_PAD; new data visible on the following read).
- Reset mid-operation: `reset`=0 while COLLECT with `rd_valid`=1 → all outputs 0 next edge; no write occurs on that edge.

Source files
------------

// File: rtl/mv_result_collector.sv
// Result collector for the matrix-by-vector engine: captures decoder chunks into an indexed
// buffer, tracks completion, and serves a registered read port. Optional: MV_COLLECTOR_ZERO_PAD_EN.
module mv_result_collector #(
    parameter int element_width = 32,
    parameter int NI            = 8,
    parameter int DEPTH         = 16,
    parameter int ADDR_W        = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [31:0]                 total_chunks,
    input  logic                        in_valid,
    input  logic [NI*element_width-1:0] in_data,
    input  logic                        rd_en,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic [NI*element_width-1:0] rd_data,
    output logic                        rd_valid,
    output logic [ADDR_W:0]             count,
    output logic                        done,
    output logic                        overflow
);

    localparam int CHUNK_W = NI * element_width;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [31:0]          target;
    logic                 wr_en;
    logic                 drop;
    logic                 last;
    logic [CHUNK_W-1:0]   rd_word;
    logic [CHUNK_W-1:0]   mem [DEPTH];

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        drop       = 1'b0;
        last       = 1'b0;
        if (!start) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = (total_chunks == 32'd0) ? DONE : COLLECT;
                COLLECT: begin
                    if (in_valid) begin
                        if (count < DEPTH_C) begin
                            wr_en = 1'b1;
                            if (32'(count) + 32'd1 == target) begin
                                last       = 1'b1;
                                state_next = DONE;
                            end
                        end else begin
                            drop = 1'b1;
                        end
                    end
                end
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset || !start) begin
            count    <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_en)                     count    <= count + ONE_C;
            if (drop)                      overflow <= 1'b1;
            if (last || state == DONE)     done     <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)                         target <= '0;
        else if (start && state == IDLE)    target <= total_chunks;
    end

    // NOTE: the buffer has no reset; reset only blocks writes, so contents survive across runs.
    always_ff @(posedge clk) begin
        if (reset && wr_en) mem[count[ADDR_W-1:0]] <= in_data;
    end

    // Pre-edge buffer contents feed the read register, giving read-before-write on collisions.
    always_comb begin
        rd_word = '0;
        if ({1'b0, rd_addr} < DEPTH_C) begin
`ifdef MV_COLLECTOR_ZERO_PAD_EN
            if ({1'b0, rd_addr} < count) rd_word = mem[rd_addr];
`else
            rd_word = mem[rd_addr];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_word;
        end
    end

endmodule

// File: tb/tb_mv_result_collector.sv
// Directed self-checking bench for mv_result_collector (default parameters).
module tb_mv_result_collector;

    localparam int W = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   total_chunks;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          rd_en;
    logic [3:0]    rd_addr;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic [4:0]    count;
    logic          done;
    logic          overflow;

    int passed = 0;
    int total  = 0;

    mv_result_collector dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .total_chunks (total_chunks),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .count        (count),
        .done         (done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pat(input logic [31:0] v);
        return {8{v}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic flags(input string tag, input logic [4:0] c, input logic d, input logic o);
        check({tag, "_count"}, W'(count), W'(c));
        check({tag, "_done"}, W'(done), W'(d));
        check({tag, "_ovf"}, W'(overflow), W'(o));
    endtask

    task automatic read(input logic [3:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
    endtask

    initial begin
        logic [W-1:0] exp;
        reset = 1'b0; start = 1'b0; total_chunks = '0; in_valid = 1'b0;
        in_data = '0; rd_en = 1'b0; rd_addr = '0;
        tick(); tick();
        flags("reset", 5'd0, 1'b0, 1'b0);
        check("reset_rd_valid", W'(rd_valid), '0);
        check("reset_rd_data", rd_data, '0);
        reset = 1'b1;
        tick();

        // Basic run of four chunks
        start = 1'b1; total_chunks = 32'd4;
        tick();
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1; in_data = pat(32'h1111_1111 * k);
            tick();
            if (k == 3) flags("basic_k3", 5'd3, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        flags("basic_end", 5'd4, 1'b1, 1'b0);
        read(4'd2);
        check("basic_rd_valid", W'(rd_valid), W'(1));
        check("basic_rd_data", rd_data, pat(32'h3333_3333));
        tick();
        check("basic_rd_valid_drop", W'(rd_valid), '0);
        check("basic_rd_hold", rd_data, pat(32'h3333_3333));
        in_valid = 1'b1; in_data = pat(32'hdead_beef);
        tick();
        in_valid = 1'b0;
        flags("done_strobe_ignored", 5'd4, 1'b1, 1'b0);
        start = 1'b0;
        tick();
        flags("basic_abort", 5'd0, 1'b0, 1'b0);

        // Zero total: done two edges after start
        start = 1'b1; total_chunks = 32'd0;
        tick();
        flags("zero_e1", 5'd0, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = pat(32'h9999_9999);
        tick();
        flags("zero_e2", 5'd0, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        flags("zero_e3", 5'd0, 1'b1, 1'b0);
        start = 1'b0;
        tick();

        // Overflow: 18 strobes against a target of 20
        start = 1'b1; total_chunks = 32'd20;
        tick();
        for (int k = 1; k <= 18; k++) begin
            in_valid = 1'b1; in_data = pat(32'ha000_0000 + k);
            tick();
            if (k == 16) flags("ovf_k16", 5'd16, 1'b0, 1'b0);
            if (k == 17) flags("ovf_k17", 5'd16, 1'b0, 1'b1);
        end
        in_valid = 1'b0;
        flags("ovf_k18", 5'd16, 1'b0, 1'b1);
        read(4'd15);
        check("ovf_rd15", rd_data, pat(32'ha000_0010));
        start = 1'b0;
        tick();
        flags("ovf_clear", 5'd0, 1'b0, 1'b0);
        read(4'd0);
`ifdef MV_COLLECTOR_ZERO_PAD_EN
        exp = '0;
`else
        exp = pat(32'ha000_0001);
`endif
        check("stale_rd0", rd_data, exp);

        // Abort mid-run: 3 of 8, then start low together with a strobe
        start = 1'b1; total_chunks = 32'd8;
        tick();
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1; in_data = pat(32'hb000_0000 + k);
            tick();
        end
        start = 1'b0; in_data = pat(32'hb000_0004);
        tick();
        in_valid = 1'b0;
        flags("abort", 5'd0, 1'b0, 1'b0);
        read(4'd0);
`ifdef MV_COLLECTOR_ZERO_PAD_EN
        exp = '0;
`else
        exp = pat(32'hb000_0001);
`endif
        check("abort_rd0", rd_data, exp);
        read(4'd3);
`ifdef MV_COLLECTOR_ZERO_PAD_EN
        exp = '0;
`else
        exp = pat(32'ha000_0004);
`endif
        check("abort_no_write", rd_data, exp);

        // Read/write collision at address count
        start = 1'b1; total_chunks = 32'd8;
        tick();
        in_valid = 1'b1; in_data = pat(32'hc000_0001);
        read(4'd0);
        in_valid = 1'b0;
`ifdef MV_COLLECTOR_ZERO_PAD_EN
        exp = '0;
`else
        exp = pat(32'hb000_0001);
`endif
        check("collide_old", rd_data, exp);
        check("collide_count", W'(count), W'(1));
        read(4'd0);
        check("collide_new", rd_data, pat(32'hc000_0001));

        // Reset mid-run with rd_valid high and a strobe pending
        in_valid = 1'b1; in_data = pat(32'hc000_0002);
        read(4'd0);
        check("pre_reset_rd_valid", W'(rd_valid), W'(1));
        reset = 1'b0; in_data = pat(32'hc000_0003);
        tick();
        in_valid = 1'b0;
        flags("midreset", 5'd0, 1'b0, 1'b0);
        check("midreset_rd_valid", W'(rd_valid), '0);
        check("midreset_rd_data", rd_data, '0);
        reset = 1'b1;
        read(4'd2);
`ifdef MV_COLLECTOR_ZERO_PAD_EN
        exp = '0;
`else
        exp = pat(32'hb000_0003);
`endif
        check("midreset_no_write", rd_data, exp);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
